// File: rtl/battery_pkg.sv
// rtl/battery_pkg.sv - shared state encoding and drain-step constants for battery_monitor
package battery_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_CHARGE   = 2'd2,
        ST_DEPLETED = 2'd3
    } state_t;

    localparam int DRAIN_STEP_NORMAL = 1;
    localparam int DRAIN_STEP_MOTOR  = 2;

endpackage

// File: rtl/battery_monitor_sync_debounce.sv
// rtl/battery_monitor_sync_debounce.sv - 2-FF synchronizer plus stability-count debounce
module sync_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            // Any cycle that agrees with the accepted value restarts the count.
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/battery_monitor.sv
// rtl/battery_monitor.sv - battery charge model, power/dock state machine and hysteretic status
module battery_monitor
    import battery_pkg::*;
#(
    parameter int LEVEL_W    = 8,
    parameter int LEVEL_MAX  = 200,
    parameter int INIT_LEVEL = LEVEL_MAX,
    parameter int LOW_TH     = 40,
    parameter int HIGH_TH    = 160,
    parameter int DRAIN_DIV  = 50,
    parameter int CHARGE_DIV = 25,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               power_sw,
    input  logic               dock,
    input  logic               motor_on,
    output logic               power,
    output logic               batery_status,
    output logic               charging,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         state
);

    localparam int DIV_MAX = (DRAIN_DIV > CHARGE_DIV) ? DRAIN_DIV : CHARGE_DIV;
    localparam int PW      = $clog2(DIV_MAX + 1);

    localparam logic [PW-1:0]      DRAIN_LAST  = PW'(DRAIN_DIV - 1);
    localparam logic [PW-1:0]      CHARGE_LAST = PW'(CHARGE_DIV - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX     = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_INIT    = LEVEL_W'(INIT_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_LOW     = LEVEL_W'(LOW_TH);
    localparam logic [LEVEL_W-1:0] LVL_HIGH    = LEVEL_W'(HIGH_TH);
    localparam logic               STATUS_INIT = (INIT_LEVEL > LOW_TH);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               status_q;
    logic               power_deb;
    logic               dock_s1_q, dock_s2_q;
    logic               tick;
    logic [LEVEL_W-1:0] drain_step;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_power_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (power_sw),
        .dout  (power_deb)
    );

    assign drain_step = motor_on ? LEVEL_W'(DRAIN_STEP_MOTOR) : LEVEL_W'(DRAIN_STEP_NORMAL);
    assign tick = ((state_q == ST_RUN)    && (presc_q == DRAIN_LAST)) ||
                  ((state_q == ST_CHARGE) && (presc_q == CHARGE_LAST));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        presc_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (dock_s2_q)                        state_d = ST_CHARGE;
                else if (power_deb && level_q != '0)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dock_s2_q)                        state_d = ST_CHARGE;
                else if (level_q == '0)               state_d = ST_DEPLETED;
                else if (!power_deb)                  state_d = ST_IDLE;
                if (tick)
                    level_d = (level_q <= drain_step) ? '0 : level_q - drain_step;
            end
            ST_CHARGE: begin
                if (!dock_s2_q) begin
                    if (level_q == '0)                state_d = ST_DEPLETED;
                    else if (power_deb)               state_d = ST_RUN;
                    else                              state_d = ST_IDLE;
                end
                if (tick)
                    level_d = (level_q >= LVL_MAX) ? LVL_MAX : level_q + 1'b1;
            end
            ST_DEPLETED: begin
                if (dock_s2_q)                        state_d = ST_CHARGE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The prescaler only runs while staying in an active state.
        if (state_d == state_q && (state_q == ST_RUN || state_q == ST_CHARGE) && !tick)
            presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            level_q   <= LVL_INIT;
            presc_q   <= '0;
            status_q  <= STATUS_INIT;
            dock_s1_q <= 1'b0;
            dock_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            presc_q   <= presc_d;
            dock_s1_q <= dock;
            dock_s2_q <= dock_s1_q;
            if (level_q <= LVL_LOW)
                status_q <= 1'b0;
            else if (level_q >= LVL_HIGH)
                status_q <= 1'b1;
        end
    end

    assign power         = power_deb && (state_q == ST_RUN);
    assign charging      = (state_q == ST_CHARGE);
    assign batery_status = status_q;
    assign level         = level_q;
    assign state         = state_q;

endmodule
